matrix_writeback: RTL and testbench

Return path of the matrix datapath: captures a result matrix presented as a parallel element array, writes it element-by-element into an internal simple dual-port RAM, then reads it back and streams it out one element per valid/ready beat. It complements the ROM-to-RAM load path, which fills RAM and unpacks it into a matrix. This block takes a matrix, packs it into RAM and drains it serially toward the output/arbiter side.

---
 rtl/matrix_writeback.sv | 132 +++++++++++++
 tb/tb_matrix_writeback.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_writeback.sv
// Result-matrix writeback: snapshots a parallel element array, packs it into an internal
// simple dual-port RAM, then reads it back and streams it out one element per valid/ready beat.
module matrix_writeback #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_AMOUNT = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned CNT_WIDTH  = $clog2(DATA_AMOUNT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  data_amt,
    input  logic [DATA_WIDTH-1:0] matrix_data [DATA_AMOUNT],
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadReq,
        StReadWait,
        StSend,
        StDone
    } state_e;

    state_e                state;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [CNT_WIDTH-1:0]  n_q;
    logic [CNT_WIDTH-1:0]  n_clamped;
    logic [CNT_WIDTH-1:0]  last_idx;
    logic                  accept;

    logic [DATA_WIDTH-1:0] snap [DATA_AMOUNT];
    logic [DATA_WIDTH-1:0] mem  [DEPTH];
    logic [DATA_WIDTH-1:0] doutb;

    assign accept    = (state == StIdle) && start && !reset;
    assign n_clamped = (data_amt > CNT_WIDTH'(DATA_AMOUNT)) ? CNT_WIDTH'(DATA_AMOUNT) : data_amt;
    assign last_idx  = n_q - CNT_WIDTH'(1);
    assign busy      = (state != StIdle);

    // Snapshot decouples the transfer from later changes on matrix_data.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < DATA_AMOUNT; i++) begin
                snap[i] <= matrix_data[i];
            end
        end
    end

    // Simple dual-port RAM: port A writes during WRITE, port B has a registered read.
    always_ff @(posedge clk) begin
        if (state == StWrite) begin
            mem[wr_idx] <= snap[wr_idx];
        end
        if (state == StReadReq) begin
            doutb <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            wr_idx    <= '0;
            rd_idx    <= '0;
            n_q       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        n_q    <= n_clamped;
                        wr_idx <= '0;
                        rd_idx <= '0;
                        if (n_clamped == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    wr_idx <= wr_idx + 1'b1;
                    if (CNT_WIDTH'(wr_idx) == last_idx) begin
                        state <= StReadReq;
                    end
                end
                StReadReq: begin
                    state <= StReadWait;
                end
                StReadWait: begin
                    out_data  <= doutb;
                    out_valid <= 1'b1;
                    out_last  <= (CNT_WIDTH'(rd_idx) == last_idx);
                    state     <= StSend;
                end
                StSend: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                            state  <= StReadReq;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_writeback.sv
// Self-checking bench for matrix_writeback: scenario tasks plus a scoreboard-driven
// output monitor that checks every accepted beat and data stability under backpressure.
module tb_matrix_writeback;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int DA = 16;
    localparam int CW = $clog2(DA + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] data_amt;
    logic [DW-1:0] matrix_data [DA];
    logic          busy;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;

    matrix_writeback #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .DATA_AMOUNT(DA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_amt   (data_amt),
        .matrix_data(matrix_data),
        .busy       (busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int beats  = 0;
    int dones  = 0;

    // Scoreboard entries are {last, data}.
    logic [DW:0] exp_q [$];

    logic          stall_pending = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    // Monitor samples on the falling edge, between input drive and the DUT's active edge.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending && out_valid) begin
                checks++;
                if (out_data !== stall_data || out_last !== stall_last)
                    $display("FAIL stall_hold: got data=%h last=%b, required data=%h last=%b",
                             out_data, out_last, stall_data, stall_last);
                else passes++;
            end
            stall_pending = 1'b0;
            if (out_valid && out_ready) begin
                beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got data=%h last=%b, required no beat",
                             out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e)
                        $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                                 out_data, out_last, e[DW-1:0], e[DW]);
                    else passes++;
                end
            end else if (out_valid) begin
                stall_pending = 1'b1;
                stall_data    = out_data;
                stall_last    = out_last;
            end
            if (done) dones++;
        end
    end

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), matrix_data[i]});
    endtask

    // Drive start for one cycle; returns just after the accepting edge E0.
    task automatic kick(input int amt);
        data_amt = CW'(amt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Observe from E0 (k=0): first k with out_valid, with done, and with busy low.
    task automatic observe(input int budget, input bit rnd, input bit poke,
                           output int fv, output int fd, output int bf);
        int pstate = 0;
        fv = -1; fd = -1; bf = -1;
        for (int k = 0; k <= budget; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (fv < 0 && out_valid) fv = k;
            if (fd < 0 && done) fd = k;
            if (!busy) begin bf = k; break; end
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (poke) begin
                start = 1'b0;
                if ((pstate == 0 && k == 2) || (pstate == 1 && out_valid)) begin
                    start = 1'b1;
                    data_amt = CW'(3);
                    for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'hEE - pstate);
                    pstate++;
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; data_amt = '0;
        for (int i = 0; i < DA; i++) matrix_data[i] = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", out_valid); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b, required 0", out_last); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else passes++;
        checks++; if (out_data !== '0) $display("FAIL reset_data: got %h, required 00", out_data); else passes++;
    endtask

    task automatic test_basic;
        int fv, fd, bf, b0, d0;
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(i + 8'h10);
        out_ready = 1'b1;
        b0 = beats; d0 = dones;
        push_exp(16);
        kick(16);
        observe(200, 1'b0, 1'b0, fv, fd, bf);
        checks++; if (fv !== 18) $display("FAIL basic_first_valid: got k=%0d, required 18", fv); else passes++;
        checks++; if (fd !== 64) $display("FAIL basic_done_time: got k=%0d, required 64", fd); else passes++;
        checks++; if (bf !== 65) $display("FAIL basic_busy_fall: got k=%0d, required 65", bf); else passes++;
        checks++; if (beats - b0 !== 16) $display("FAIL basic_beats: got %0d, required 16", beats - b0); else passes++;
        checks++; if (dones - d0 !== 1) $display("FAIL basic_dones: got %0d, required 1", dones - d0); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_backpressure;
        int fv, fd, bf, b0, d0;
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(i * 3);
        b0 = beats; d0 = dones;
        push_exp(4);
        kick(4);
        observe(400, 1'b1, 1'b0, fv, fd, bf);
        checks++; if (bf < 0) $display("FAIL bp_timeout: got no busy fall, required one"); else passes++;
        checks++; if (beats - b0 !== 4) $display("FAIL bp_beats: got %0d, required 4", beats - b0); else passes++;
        checks++; if (dones - d0 !== 1) $display("FAIL bp_dones: got %0d, required 1", dones - d0); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL bp_leftover: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_snapshot;
        int fv, fd, bf, b0, d0;
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'hA0 + i);
        b0 = beats; d0 = dones;
        push_exp(6);
        kick(6);
        observe(200, 1'b0, 1'b1, fv, fd, bf);
        repeat (4) begin
            @(posedge clk); #1;
            checks++; if (busy !== 1'b0) $display("FAIL snap_restart: got busy=%b, required 0", busy); else passes++;
        end
        checks++; if (bf !== 25) $display("FAIL snap_busy_fall: got k=%0d, required 25", bf); else passes++;
        checks++; if (beats - b0 !== 6) $display("FAIL snap_beats: got %0d, required 6", beats - b0); else passes++;
        checks++; if (dones - d0 !== 1) $display("FAIL snap_dones: got %0d, required 1", dones - d0); else passes++;
    endtask

    task automatic test_zero_clamp;
        int fv, fd, bf, b0, d0;
        b0 = beats; d0 = dones;
        kick(0);
        observe(20, 1'b0, 1'b0, fv, fd, bf);
        checks++; if (fd !== 0) $display("FAIL zero_done_time: got k=%0d, required 0", fd); else passes++;
        checks++; if (fv !== -1) $display("FAIL zero_valid: got k=%0d, required never", fv); else passes++;
        checks++; if (bf !== 1) $display("FAIL zero_busy_fall: got k=%0d, required 1", bf); else passes++;
        checks++; if (beats - b0 !== 0) $display("FAIL zero_beats: got %0d, required 0", beats - b0); else passes++;
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'h55 ^ i);
        b0 = beats;
        push_exp(16);
        kick(31);
        observe(200, 1'b0, 1'b0, fv, fd, bf);
        checks++; if (beats - b0 !== 16) $display("FAIL clamp_beats: got %0d, required 16", beats - b0); else passes++;
        checks++; if (dones - d0 !== 2) $display("FAIL clamp_dones: got %0d, required 2", dones - d0); else passes++;
    endtask

    task automatic test_reset_midstream;
        int fv, fd, bf, b0, d0;
        bit ok = 1'b0;
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'h30 + i);
        b0 = beats;
        push_exp(8);
        kick(8);
        for (int k = 0; k < 100; k++) begin
            if (beats - b0 >= 3) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!ok) $display("FAIL rst_wait: got %0d beats, required 3", beats - b0); else passes++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rst_data: got %h, required 00", out_data); else passes++;
        exp_q.delete();
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'hC0 + i);
        b0 = beats; d0 = dones;
        push_exp(2);
        kick(2);
        observe(100, 1'b0, 1'b0, fv, fd, bf);
        checks++; if (beats - b0 !== 2) $display("FAIL rst_new_beats: got %0d, required 2", beats - b0); else passes++;
        checks++; if (dones - d0 !== 1) $display("FAIL rst_new_dones: got %0d, required 1", dones - d0); else passes++;
    endtask

    task automatic test_back_to_back;
        int fv, fd, bf, b0, d0;
        b0 = beats; d0 = dones;
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'h70 + i);
        push_exp(3);
        kick(3);
        observe(100, 1'b0, 1'b0, fv, fd, bf);
        for (int i = 0; i < DA; i++) matrix_data[i] = DW'(8'h90 - i);
        push_exp(5);
        kick(5);
        observe(100, 1'b0, 1'b0, fv, fd, bf);
        checks++; if (fv !== 7) $display("FAIL b2b_first_valid: got k=%0d, required 7", fv); else passes++;
        checks++; if (beats - b0 !== 8) $display("FAIL b2b_beats: got %0d, required 8", beats - b0); else passes++;
        checks++; if (dones - d0 !== 2) $display("FAIL b2b_dones: got %0d, required 2", dones - d0); else passes++;
        checks++; if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_zero_clamp();
        test_reset_midstream();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
